// File: rtl/uds_job_if.sv
// uds_job_if: command, tile-fetch, UDS control, result and status signals of uds_job_ctrl
//   slave  : view of the job controller (drives cmd_ready, tile_req, uds_*, out_*, status)
//   master : view of the surrounding scheduler / buffer / UDS / writer environment
interface uds_job_if #(
    parameter int TILE_CNT_W = 8
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [1:0]            cmd_mode;
    logic [1:0]            cmd_scale;
    logic [TILE_CNT_W-1:0] cmd_tiles;
    logic                  tile_req;
    logic                  tile_ack;
    logic                  uds_idata_valid;
    logic                  uds_active;
    logic [1:0]            uds_function_mode;
    logic [1:0]            uds_scale_factor;
    logic                  uds_odata_valid;
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_last;
    logic                  busy;
    logic                  done;
    logic [TILE_CNT_W-1:0] tiles_done;
    logic                  err_cfg;
    logic                  err_timeout;
    logic                  err_overrun;

    modport slave (
        input  cmd_valid, cmd_mode, cmd_scale, cmd_tiles, tile_ack, uds_odata_valid, out_ready,
        output cmd_ready, tile_req, uds_idata_valid, uds_active, uds_function_mode, uds_scale_factor,
               out_valid, out_last, busy, done, tiles_done, err_cfg, err_timeout, err_overrun
    );

    modport master (
        output cmd_valid, cmd_mode, cmd_scale, cmd_tiles, tile_ack, uds_odata_valid, out_ready,
        input  cmd_ready, tile_req, uds_idata_valid, uds_active, uds_function_mode, uds_scale_factor,
               out_valid, out_last, busy, done, tiles_done, err_cfg, err_timeout, err_overrun
    );
endinterface

// File: rtl/uds_job_ctrl.sv
// uds_job_ctrl: job sequencer for the 8x8 upsample/downsample engine (control only, no data path)
//   clk, rst : clock, synchronous active-high reset
//   bus      : uds_job_if.slave -- command accept, tile fetch, UDS load/compute control,
//              result beat forwarding under valid/ready, job status and sticky errors
module uds_job_ctrl #(
    parameter int TILE_CNT_W  = 8,
    parameter int COMPUTE_CYC = 1,
    parameter int TIMEOUT     = 15
) (
    input logic     clk,
    input logic     rst,
    uds_job_if.slave bus
);
    typedef enum logic [2:0] {IDLE, FETCH, COMPUTE, WAITO, DRAIN, DONE} state_t;

    localparam logic [7:0] CC_END = 8'(COMPUTE_CYC - 1);
    localparam logic [7:0] TO_END = 8'(TIMEOUT - 1);

    state_t                state_q, state_d;
    logic [1:0]            mode_q, mode_d, scale_q, scale_d, beats_q, beats_d;
    logic [TILE_CNT_W-1:0] rem_q, rem_d, tiles_done_q, tiles_done_d;
    logic [7:0]            cnt_q, cnt_d;
    logic                  err_cfg_q, err_cfg_d, err_to_q, err_to_d, err_ov_q, err_ov_d;
    logic                  accept, hs, beat;

    assign accept = state_q == IDLE && bus.cmd_valid;
    assign hs     = state_q == DRAIN && bus.out_ready;
    assign beat   = bus.uds_odata_valid;

    always_comb begin
        state_d      = state_q;
        mode_d       = accept ? bus.cmd_mode : mode_q;
        scale_d      = accept ? bus.cmd_scale : scale_q;
        rem_d        = accept ? bus.cmd_tiles : rem_q;
        tiles_done_d = accept ? '0 : tiles_done_q;
        beats_d      = beats_q;
        err_cfg_d    = accept ? 1'b0 : err_cfg_q;
        err_to_d     = accept ? 1'b0 : err_to_q;
        err_ov_d     = accept ? 1'b0 : err_ov_q;
        case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    if (!bus.cmd_mode[1] && bus.cmd_scale[1]) begin
                        err_cfg_d = 1'b1;
                        state_d   = DONE;
                    end else begin
                        state_d = (bus.cmd_tiles == '0) ? DONE : FETCH;
                    end
                end
            end
            FETCH: begin
                beats_d = mode_q[1] ? 2'd2 : 2'd1;
                if (bus.tile_ack) state_d = COMPUTE;
            end
            COMPUTE: begin
                if (cnt_q == CC_END) state_d = WAITO;
            end
            WAITO: begin
                if (beat) begin
                    beats_d = beats_q - 2'd1;
                    state_d = DRAIN;
                end else if (cnt_q == TO_END) begin
                    err_to_d = 1'b1;
                    state_d  = DONE;
                end
            end
            DRAIN: begin
                if (hs) begin
                    if (beats_q != 2'd0) begin
                        // a beat landing on the handshake becomes the new pending beat
                        if (beat) beats_d = beats_q - 2'd1;
                        else state_d = WAITO;
                    end else begin
                        err_ov_d     = err_ov_d | beat;
                        tiles_done_d = &tiles_done_q ? tiles_done_q : tiles_done_q + 1'b1;
                        rem_d        = rem_q - 1'b1;
                        state_d      = (rem_q == TILE_CNT_W'(1)) ? DONE : FETCH;
                    end
                end else if (beat) begin
                    // beat lost behind a stalled one still counts toward the tile
                    err_ov_d = 1'b1;
                    beats_d  = (beats_q == 2'd0) ? 2'd0 : beats_q - 2'd1;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (beat && (state_q == IDLE || state_q == FETCH || state_q == COMPUTE || state_q == DONE))
            err_ov_d = 1'b1;
        // one counter serves both compute length and result timeout; it restarts on every state change
        cnt_d = (state_d != state_q) ? 8'd0 : cnt_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            mode_q       <= '0;
            scale_q      <= '0;
            beats_q      <= '0;
            rem_q        <= '0;
            tiles_done_q <= '0;
            cnt_q        <= '0;
            err_cfg_q    <= 1'b0;
            err_to_q     <= 1'b0;
            err_ov_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            scale_q      <= scale_d;
            beats_q      <= beats_d;
            rem_q        <= rem_d;
            tiles_done_q <= tiles_done_d;
            cnt_q        <= cnt_d;
            err_cfg_q    <= err_cfg_d;
            err_to_q     <= err_to_d;
            err_ov_q     <= err_ov_d;
        end
    end

    assign bus.cmd_ready         = state_q == IDLE;
    assign bus.tile_req          = state_q == FETCH;
    assign bus.uds_idata_valid   = state_q == FETCH && bus.tile_ack;
    assign bus.uds_active        = state_q == COMPUTE;
    assign bus.uds_function_mode = mode_q;
    assign bus.uds_scale_factor  = scale_q;
    assign bus.out_valid         = state_q == DRAIN;
    assign bus.out_last          = state_q == DRAIN && beats_q == 2'd0 && rem_q == TILE_CNT_W'(1);
    assign bus.busy              = state_q != IDLE;
    assign bus.done              = state_q == DONE;
    assign bus.tiles_done        = tiles_done_q;
    assign bus.err_cfg           = err_cfg_q;
    assign bus.err_timeout       = err_to_q;
    assign bus.err_overrun       = err_ov_q;
endmodule

// File: tb/tb_uds_job_ctrl.sv
// tb_uds_job_ctrl: self-checking bench for uds_job_ctrl with directed scenarios and randomized jobs
module tb_uds_job_ctrl;
    localparam int TW = 8;
    localparam int CC = 1;
    localparam int TO = 15;
    localparam logic [TW+14:0] RST_OUTS = {1'b1, {(TW+14){1'b0}}};

    logic clk = 1'b0;
    logic rst;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    uds_job_if #(.TILE_CNT_W(TW)) bus ();

    uds_job_ctrl #(.TILE_CNT_W(TW), .COMPUTE_CYC(CC), .TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [TW+14:0] outs;
    assign outs = {bus.cmd_ready, bus.tile_req, bus.uds_idata_valid, bus.uds_active,
                   bus.uds_function_mode, bus.uds_scale_factor, bus.out_valid, bus.out_last,
                   bus.busy, bus.done, bus.tiles_done, bus.err_cfg, bus.err_timeout, bus.err_overrun};

    task automatic clear_inputs;
        bus.cmd_valid       = 1'b0;
        bus.cmd_mode        = 2'd0;
        bus.cmd_scale       = 2'd0;
        bus.cmd_tiles       = '0;
        bus.tile_ack        = 1'b0;
        bus.uds_odata_valid = 1'b0;
        bus.out_ready       = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge following the accepting edge.
    task automatic send_cmd(input logic [1:0] m, input logic [1:0] s, input logic [TW-1:0] t);
        int k;
        k = 0;
        while (!bus.cmd_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        n_chk++;
        if (bus.cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL cmd_ready_wait: cmd_ready=%b required 1", bus.cmd_ready);
        end
        bus.cmd_valid = 1'b1;
        bus.cmd_mode  = m;
        bus.cmd_scale = s;
        bus.cmd_tiles = t;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        clear_inputs();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_chk++;
        if (outs !== RST_OUTS) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h required %h", outs, RST_OUTS);
        end
    endtask

    task automatic test_cfg_error;
        send_cmd(2'b00, 2'd2, TW'(3));
        n_chk++;
        if ({bus.done, bus.err_cfg, bus.tile_req} !== 3'b110) begin
            n_fail++;
            $display("FAIL cfg_error: done/err_cfg/tile_req=%b required 110", {bus.done, bus.err_cfg, bus.tile_req});
        end
        @(negedge clk);
        n_chk++;
        if ({bus.done, bus.cmd_ready, bus.tile_req, bus.err_cfg} !== 4'b0101) begin
            n_fail++;
            $display("FAIL cfg_after: done/cmd_ready/tile_req/err_cfg=%b required 0101",
                     {bus.done, bus.cmd_ready, bus.tile_req, bus.err_cfg});
        end
        send_cmd(2'b10, 2'd3, TW'(0));
        n_chk++;
        if ({bus.done, bus.err_cfg, bus.tiles_done} !== {2'b10, {TW{1'b0}}}) begin
            n_fail++;
            $display("FAIL cfg_clear_zero_tiles: done=%b err_cfg=%b tiles_done=%0d required 1 0 0",
                     bus.done, bus.err_cfg, bus.tiles_done);
        end
        n_chk++;
        if ({bus.uds_function_mode, bus.uds_scale_factor} !== 4'b1011) begin
            n_fail++;
            $display("FAIL cfg_latch: mode/scale=%b required 1011", {bus.uds_function_mode, bus.uds_scale_factor});
        end
        @(negedge clk);
    endtask

    task automatic test_timeout;
        int k, bad;
        send_cmd(2'b10, 2'd0, TW'(1));
        bus.tile_ack = 1'b1;
        @(negedge clk);
        bus.tile_ack = 1'b0;
        n_chk++;
        if (bus.uds_active !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_compute: uds_active=%b required 1", bus.uds_active);
        end
        @(negedge clk);
        k = 0;
        bad = 0;
        while (!bus.err_timeout && k < 40) begin
            if (bus.out_valid || bus.out_last) bad++;
            @(negedge clk);
            k++;
        end
        n_chk++;
        if (k != TO) begin
            n_fail++;
            $display("FAIL timeout_delay: err_timeout after %0d cycles required %0d", k, TO);
        end
        n_chk++;
        if ({bus.done, bus.out_last, bus.err_overrun, bus.tiles_done} !== {3'b100, {TW{1'b0}}} || bad != 0) begin
            n_fail++;
            $display("FAIL timeout_end: done=%b out_last=%b err_overrun=%b tiles_done=%0d stray_out=%0d required 1 0 0 0 0",
                     bus.done, bus.out_last, bus.err_overrun, bus.tiles_done, bad);
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure_overrun;
        int bad;
        send_cmd(2'b10, 2'd0, TW'(2));
        bus.tile_ack = 1'b1;
        @(negedge clk);
        bus.tile_ack = 1'b0;
        @(negedge clk);
        bus.uds_odata_valid = 1'b1;
        @(negedge clk);
        bus.uds_odata_valid = 1'b0;
        bus.out_ready = 1'b0;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (!bus.out_valid || bus.tile_req) bad++;
            bus.uds_odata_valid = (i == 3);
            @(negedge clk);
        end
        bus.uds_odata_valid = 1'b0;
        n_chk++;
        if (bad != 0 || bus.out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_hold: bad_cycles=%0d out_valid=%b required 0 1", bad, bus.out_valid);
        end
        n_chk++;
        if ({bus.err_overrun, bus.out_last} !== 2'b10) begin
            n_fail++;
            $display("FAIL overrun_flag: err_overrun/out_last=%b required 10", {bus.err_overrun, bus.out_last});
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        n_chk++;
        if ({bus.tile_req, bus.out_valid, bus.tiles_done} !== {2'b10, TW'(1)}) begin
            n_fail++;
            $display("FAIL overrun_tile_done: tile_req=%b out_valid=%b tiles_done=%0d required 1 0 1",
                     bus.tile_req, bus.out_valid, bus.tiles_done);
        end
        bus.tile_ack = 1'b1;
        @(negedge clk);
        bus.tile_ack = 1'b0;
        @(negedge clk);
        bus.uds_odata_valid = 1'b1;
        @(negedge clk);
        bus.uds_odata_valid = 1'b0;
        n_chk++;
        if ({bus.out_valid, bus.out_last} !== 2'b10) begin
            n_fail++;
            $display("FAIL up_beat3: out_valid/out_last=%b required 10", {bus.out_valid, bus.out_last});
        end
        @(negedge clk);
        bus.uds_odata_valid = 1'b1;
        @(negedge clk);
        bus.uds_odata_valid = 1'b0;
        n_chk++;
        if ({bus.out_valid, bus.out_last} !== 2'b11) begin
            n_fail++;
            $display("FAIL up_beat4_last: out_valid/out_last=%b required 11", {bus.out_valid, bus.out_last});
        end
        @(negedge clk);
        n_chk++;
        if ({bus.done, bus.err_overrun, bus.tiles_done} !== {2'b11, TW'(2)}) begin
            n_fail++;
            $display("FAIL up_job_end: done=%b err_overrun=%b tiles_done=%0d required 1 1 2",
                     bus.done, bus.err_overrun, bus.tiles_done);
        end
        bus.out_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        send_cmd(2'b01, 2'd1, TW'(4));
        bus.tile_ack = 1'b1;
        @(negedge clk);
        bus.tile_ack = 1'b0;
        @(negedge clk);
        bus.uds_odata_valid = 1'b1;
        @(negedge clk);
        bus.uds_odata_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.tile_ack = 1'b1;
        @(negedge clk);
        bus.tile_ack = 1'b0;
        n_chk++;
        if ({bus.uds_active, bus.tiles_done} !== {1'b1, TW'(1)}) begin
            n_fail++;
            $display("FAIL mid_tile2_compute: uds_active=%b tiles_done=%0d required 1 1", bus.uds_active, bus.tiles_done);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_chk++;
        if (outs !== RST_OUTS) begin
            n_fail++;
            $display("FAIL mid_reset_outputs: got %h required %h", outs, RST_OUTS);
        end
        send_cmd(2'b00, 2'd0, TW'(1));
        bus.tile_ack = 1'b1;
        @(negedge clk);
        bus.tile_ack = 1'b0;
        @(negedge clk);
        bus.uds_odata_valid = 1'b1;
        @(negedge clk);
        bus.uds_odata_valid = 1'b0;
        n_chk++;
        if ({bus.out_valid, bus.out_last} !== 2'b11) begin
            n_fail++;
            $display("FAIL post_reset_last: out_valid/out_last=%b required 11", {bus.out_valid, bus.out_last});
        end
        @(negedge clk);
        n_chk++;
        if ({bus.done, bus.err_cfg, bus.err_timeout, bus.err_overrun, bus.tiles_done} !== {4'b1000, TW'(1)}) begin
            n_fail++;
            $display("FAIL post_reset_job: done/errs=%b tiles_done=%0d required 1000 1",
                     {bus.done, bus.err_cfg, bus.err_timeout, bus.err_overrun}, bus.tiles_done);
        end
        bus.out_ready = 1'b0;
        @(negedge clk);
    endtask

    // Environment plays tile buffer, UDS and writer with random delays; the expected job outcome
    // comes from the job rules: beats = tiles * (upsample ? 2 : 1), last flag on the final beat only.
    task automatic test_random_jobs;
        logic [1:0] m, s;
        logic       illegal, rdy, beat;
        int         t, nb, exp_beats, hs, last_bad, req_bad, ack_cnt, pend, gap, c;
        for (int j = 0; j < 24; j++) begin
            m = 2'($urandom_range(0, 3));
            s = 2'((j % 5 == 4) ? $urandom_range(2, 3) : $urandom_range(0, 1));
            t = (j < 2) ? 3 : $urandom_range(0, 4);
            illegal = !m[1] && s[1];
            nb = m[1] ? 2 : 1;
            exp_beats = illegal ? 0 : t * nb;
            bus.tile_ack = 1'b0;
            bus.uds_odata_valid = 1'b0;
            send_cmd(m, s, TW'(t));
            n_chk++;
            if ({bus.uds_function_mode, bus.uds_scale_factor} !== {m, s}) begin
                n_fail++;
                $display("FAIL rnd_latch job %0d: mode/scale=%b required %b", j,
                         {bus.uds_function_mode, bus.uds_scale_factor}, {m, s});
            end
            hs = 0; last_bad = 0; req_bad = 0; pend = 0; gap = 0; c = 0;
            ack_cnt = $urandom_range(0, 3);
            while (!bus.done && c < 3000) begin
                rdy = $urandom_range(0, 9) < 7;
                bus.tile_ack = bus.tile_req && ack_cnt == 0;
                if (bus.tile_req) ack_cnt = (ack_cnt == 0) ? $urandom_range(0, 3) : ack_cnt - 1;
                if (bus.uds_active) begin
                    pend = nb;
                    gap = $urandom_range(0, 4);
                end
                beat = !bus.uds_active && pend > 0 && gap == 0 && !(bus.out_valid && !rdy);
                if (beat) begin
                    pend--;
                    gap = $urandom_range(0, 3);
                end else if (!bus.uds_active && gap > 0) gap--;
                bus.uds_odata_valid = beat;
                bus.out_ready = rdy;
                if (bus.out_valid && rdy) begin
                    hs++;
                    if (bus.out_last !== (hs == exp_beats)) last_bad++;
                end
                if (bus.out_last && !bus.out_valid) last_bad++;
                if (bus.tile_req && bus.out_valid) req_bad++;
                @(negedge clk);
                c++;
            end
            bus.tile_ack = 1'b0;
            bus.uds_odata_valid = 1'b0;
            n_chk++;
            if (c >= 3000 || hs != exp_beats || last_bad != 0 || req_bad != 0) begin
                n_fail++;
                $display("FAIL rnd_flow job %0d: cycles=%0d beats=%0d last_errs=%0d req_during_drain=%0d required beats=%0d",
                         j, c, hs, last_bad, req_bad, exp_beats);
            end
            n_chk++;
            if ({bus.err_cfg, bus.err_timeout, bus.err_overrun, bus.tiles_done} !== {illegal, 2'b00, TW'(illegal ? 0 : t)}) begin
                n_fail++;
                $display("FAIL rnd_status job %0d: errs=%b tiles_done=%0d required errs=%b00 tiles_done=%0d",
                         j, {bus.err_cfg, bus.err_timeout, bus.err_overrun}, bus.tiles_done, illegal, illegal ? 0 : t);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_cfg_error();
        test_timeout();
        test_backpressure_overrun();
        test_reset_mid();
        test_random_jobs();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
